// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    // Datapath widths for the fetch/decode boundary and the instruction bus.
    localparam int CPU_ADDR_WIDTH  = 32;
    localparam int CPU_INSTR_WIDTH = 32;

    // Fetch FSM encodings, kept as plain constants so older code can share them.
    localparam logic [1:0] CPU_FETCH_RST  = 2'd0;
    localparam logic [1:0] CPU_FETCH_REQ  = 2'd1;
    localparam logic [1:0] CPU_FETCH_HOLD = 2'd2;

    // Instruction presented to decode when nothing valid is available.
    localparam logic [CPU_INSTR_WIDTH-1:0] CPU_NOP_INSTR = 32'h0000_0000;

    // One-entry hold buffer: the word and the address it came from.
    typedef struct packed {
        logic [CPU_INSTR_WIDTH-1:0] instr;
        logic [CPU_ADDR_WIDTH-1:0]  pc;
    } fetch_hold_t;

    // Force a byte address onto a word boundary.
    function automatic logic [CPU_ADDR_WIDTH-1:0] align_word(
        input logic [CPU_ADDR_WIDTH-1:0] addr
    );
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction bus between the fetch stage (master) and memory (slave).
interface fetch_if;
    import fetch_pkg::*;

    logic [CPU_ADDR_WIDTH-1:0]  o_IAddr;  // word address, held until i_IRdy
    logic                       o_IRd;    // read request
    logic [CPU_INSTR_WIDTH-1:0] i_IData;  // read data, valid with i_IRdy
    logic                       i_IRdy;   // request completes this cycle

    modport master (
        output o_IAddr,
        output o_IRd,
        input  i_IData,
        input  i_IRdy
    );

    modport slave (
        input  o_IAddr,
        input  o_IRd,
        output i_IData,
        output i_IRdy
    );

endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time on the
// instruction bus, and presents each returned word with its PC to decode.
// A single-entry hold buffer parks a returning word while downstream stalls.
// Redirects take effect on the next request issued (the in-flight word is the
// branch delay slot); drops squash the presented word and any in-flight word.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [CPU_ADDR_WIDTH-1:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       i_exec_stall,
    input  logic                       i_mem_stall,
    input  logic                       i_drop,
    input  logic                       i_jump_valid,
    input  logic [CPU_ADDR_WIDTH-1:0]  i_jump_addr,
    fetch_if.master                    ibus,
    output logic [CPU_INSTR_WIDTH-1:0] o_instr,
    output logic [CPU_ADDR_WIDTH-1:0]  o_pc,
    output logic                       o_fetch_stall
);

    logic [1:0]                 state_q,     state_d;
    logic [CPU_ADDR_WIDTH-1:0]  addr_q,      addr_d;
    logic [CPU_INSTR_WIDTH-1:0] instr_q,     instr_d;
    logic [CPU_ADDR_WIDTH-1:0]  pc_q,        pc_d;
    logic                       jump_pend_q, jump_pend_d;
    logic [CPU_ADDR_WIDTH-1:0]  jump_addr_q, jump_addr_d;
    logic                       drop_pend_q, drop_pend_d;
    fetch_hold_t                hold_q,      hold_d;

    logic                       ext_stall;
    logic                       issue_next;
    logic [CPU_ADDR_WIDTH-1:0]  next_addr;

    assign ext_stall = i_exec_stall | i_mem_stall;

    // Address of the next request: a redirect arriving this cycle wins over a
    // latched one, otherwise fall through sequentially (wraps naturally at 2^32).
    always_comb begin
        if (i_jump_valid) begin
            next_addr = align_word(i_jump_addr);
        end else if (jump_pend_q) begin
            next_addr = align_word(jump_addr_q);
        end else begin
            next_addr = addr_q + 32'd4;
        end
    end

    // Next-state logic for the FSM, PC/instruction outputs and pending flags.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        jump_pend_d = jump_pend_q;
        jump_addr_d = jump_addr_q;
        drop_pend_d = drop_pend_q;
        hold_d      = hold_q;
        issue_next  = 1'b0;

        // A later redirect before the target is used simply replaces it.
        if (i_jump_valid) begin
            jump_pend_d = 1'b1;
            jump_addr_d = i_jump_addr;
        end

        case (state_q)
            CPU_FETCH_RST: begin
                state_d = CPU_FETCH_REQ;
                addr_d  = RESET_ADDR;
            end

            CPU_FETCH_REQ: begin
                if (ibus.i_IRdy) begin
                    if (drop_pend_q || i_drop) begin
                        // Word belongs to a squashed stream: throw it away.
                        drop_pend_d = 1'b0;
                        issue_next  = 1'b1;
                    end else if (ext_stall) begin
                        // Decode cannot take it yet; park it and stop fetching.
                        hold_d.instr = ibus.i_IData;
                        hold_d.pc    = addr_q;
                        state_d      = CPU_FETCH_HOLD;
                    end else begin
                        instr_d    = ibus.i_IData;
                        pc_d       = addr_q;
                        issue_next = 1'b1;
                    end
                end else if (i_drop) begin
                    // Request cannot be aborted, so remember to discard its data.
                    drop_pend_d = 1'b1;
                end
            end

            CPU_FETCH_HOLD: begin
                if (i_drop) begin
                    hold_d     = '0;
                    issue_next = 1'b1;
                end else if (!ext_stall) begin
                    instr_d    = hold_q.instr;
                    pc_d       = hold_q.pc;
                    hold_d     = '0;
                    issue_next = 1'b1;
                end
            end

            default: begin
                state_d = CPU_FETCH_RST;
            end
        endcase

        // Starting a new request consumes any pending redirect.
        if (issue_next) begin
            state_d     = CPU_FETCH_REQ;
            addr_d      = next_addr;
            jump_pend_d = 1'b0;
        end

        // Drop overrides whatever would have been presented to decode.
        if (i_drop) begin
            instr_d = CPU_NOP_INSTR;
        end
    end

    // State registers, cleared asynchronously so reset works mid-transaction.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= CPU_FETCH_RST;
            addr_q      <= RESET_ADDR;
            instr_q     <= CPU_NOP_INSTR;
            pc_q        <= '0;
            jump_pend_q <= 1'b0;
            jump_addr_q <= '0;
            drop_pend_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            jump_pend_q <= jump_pend_d;
            jump_addr_q <= jump_addr_d;
            drop_pend_q <= drop_pend_d;
            hold_q      <= hold_d;
        end
    end

    // Bus request and stall indication are decoded from the current state.
    always_comb begin
        ibus.o_IRd    = (state_q == CPU_FETCH_REQ);
        ibus.o_IAddr  = addr_q;
        o_instr       = instr_q;
        o_pc          = pc_q;
        case (state_q)
            CPU_FETCH_REQ:  o_fetch_stall = !ibus.i_IRdy;
            CPU_FETCH_HOLD: o_fetch_stall = 1'b0;
            default:        o_fetch_stall = 1'b1;
        endcase
    end

endmodule
